// File: rtl/seq_alu.sv
`timescale 1ns/1ps
// seq_alu: signed WIDTH-bit add / subtract / multiply with a 2*WIDTH-bit result.
// Add, subtract and clear take one EXEC cycle. Multiply is iterative shift-add
// on operand magnitudes, retiring MUL_STEP multiplier bits per RUN cycle, with
// the sign applied in FIX.
// Optional feature macro: SEQ_ALU_OVF_EN. When defined, ovf is registered with C.
// When undefined, ovf is tied to 0.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. Upstream holds A/B/opCode stable with in_valid until accepted.
// out_valid with C stays asserted and unchanged until out_ready is seen high.
// in_ready never depends on in_valid.
module seq_alu #(
    parameter int WIDTH    = 64,
    parameter int MUL_STEP = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [1:0]           opCode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   C,
    output logic                 ovf
);

    localparam int ITER = WIDTH / MUL_STEP;
    localparam int CW   = (ITER > 1) ? $clog2(ITER) : 1;

    localparam logic [1:0] OP_CLR = 2'd0;
    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_SUB = 2'd3;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        EXEC = 3'd1,
        RUN  = 3'd2,
        FIX  = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t                state;
    state_t                state_next;

    logic [WIDTH-1:0]      a_r;
    logic [WIDTH-1:0]      b_r;
    logic [1:0]            op_r;
    logic [2*WIDTH-1:0]    mcand;
    logic [WIDTH-1:0]      mplier;
    logic [2*WIDTH-1:0]    acc;
    logic                  sign_r;
    logic [CW-1:0]         cnt;
    logic [2*WIDTH-1:0]    c_r;

    logic                  accept;
    logic [WIDTH:0]        add_sum;
    logic [WIDTH:0]        sub_diff;
    logic [WIDTH-1:0]      mag_a;
    logic [WIDTH-1:0]      mag_b;
    logic [2*WIDTH-1:0]    pp;
    logic [2*WIDTH-1:0]    fix_val;

    assign in_ready  = !reset && ((state == IDLE) || (state == DONE && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign C         = c_r;

    // Exact (WIDTH+1)-bit sum/difference of the captured signed operands.
    assign add_sum  = {a_r[WIDTH-1], a_r} + {b_r[WIDTH-1], b_r};
    assign sub_diff = {a_r[WIDTH-1], a_r} - {b_r[WIDTH-1], b_r};

    // Magnitudes: the most negative value negates to itself, which read as
    // unsigned is exactly 2^(WIDTH-1).
    assign mag_a = a_r[WIDTH-1] ? -a_r : a_r;
    assign mag_b = b_r[WIDTH-1] ? -b_r : b_r;

    assign fix_val = sign_r ? -acc : acc;

    // Sum of partial products for the low MUL_STEP multiplier bits this cycle.
    always_comb begin
        pp = '0;
        for (int j = 0; j < MUL_STEP; j++) begin
            if (mplier[j]) begin
                pp = pp + (mcand << j);
            end
        end
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) state_next = EXEC;
            end
            EXEC: begin
                state_next = (op_r == OP_MUL) ? RUN : DONE;
            end
            RUN: begin
                if (cnt == '0) state_next = FIX;
            end
            FIX: begin
                state_next = DONE;
            end
            DONE: begin
                if (out_ready) state_next = accept ? EXEC : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Operand capture, multiply datapath and result register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_r    <= '0;
            b_r    <= '0;
            op_r   <= '0;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            sign_r <= 1'b0;
            cnt    <= '0;
            c_r    <= '0;
        end else begin
            if (accept) begin
                a_r  <= A;
                b_r  <= B;
                op_r <= opCode;
            end
            case (state)
                EXEC: begin
                    case (op_r)
                        OP_CLR: c_r <= '0;
                        OP_ADD: c_r <= {{(WIDTH-1){add_sum[WIDTH]}}, add_sum};
                        OP_SUB: c_r <= {{(WIDTH-1){sub_diff[WIDTH]}}, sub_diff};
                        default: begin
                            mcand  <= {{WIDTH{1'b0}}, mag_a};
                            mplier <= mag_b;
                            acc    <= '0;
                            sign_r <= a_r[WIDTH-1] ^ b_r[WIDTH-1];
                            cnt    <= CW'(ITER - 1);
                        end
                    endcase
                end
                RUN: begin
                    acc    <= acc + pp;
                    mcand  <= mcand << MUL_STEP;
                    mplier <= mplier >> MUL_STEP;
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                FIX: begin
                    c_r <= fix_val;
                end
                default: ;
            endcase
        end
    end

`ifdef SEQ_ALU_OVF_EN
    logic ovf_r;
    logic mul_ovf;

    // Product overflows when the upper bits are not a pure sign extension.
    assign mul_ovf = !((&fix_val[2*WIDTH-1:WIDTH-1]) || !(|fix_val[2*WIDTH-1:WIDTH-1]));
    assign ovf     = ovf_r;

    // Overflow flag, written on the same edge as C.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovf_r <= 1'b0;
        end else begin
            case (state)
                EXEC: begin
                    case (op_r)
                        OP_CLR: ovf_r <= 1'b0;
                        OP_ADD: ovf_r <= add_sum[WIDTH] ^ add_sum[WIDTH-1];
                        OP_SUB: ovf_r <= sub_diff[WIDTH] ^ sub_diff[WIDTH-1];
                        default: ;
                    endcase
                end
                FIX:     ovf_r <= mul_ovf;
                default: ;
            endcase
        end
    end
`else
    assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_seq_alu.sv
`timescale 1ns/1ps
// Bench for seq_alu: directed vectors on a WIDTH=64/MUL_STEP=1 instance and a
// MUL_STEP=4 instance, backpressure, mid-operation reset, and a random stream
// checked against a queue of expected results.
module tb_seq_alu;

    localparam int W = 64;

    localparam logic [1:0] OP_CLR = 2'd0;
    localparam logic [1:0] OP_ADD = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_SUB = 2'd3;

`ifdef SEQ_ALU_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    localparam logic [2*W-1:0] EXP_ADD_MAX = 128'h0000_0000_0000_0000_8000_0000_0000_0000;
    localparam logic [2*W-1:0] EXP_M2      = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE;
    localparam logic [2*W-1:0] EXP_2P126   = 128'h4000_0000_0000_0000_0000_0000_0000_0000;
    localparam logic [2*W-1:0] EXP_M42     = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFD6;
    localparam logic [W-1:0]   MIN_NEG     = 64'h8000_0000_0000_0000;
    localparam logic [W-1:0]   MAX_POS     = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [W-1:0]   NEG7        = 64'hFFFF_FFFF_FFFF_FFF9;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic             in_valid, in_valid4;
    logic             in_ready, in_ready4;
    logic [W-1:0]     A, B;
    logic [1:0]       opCode;
    logic             out_valid, out_valid4;
    logic             out_ready;
    logic [2*W-1:0]   C, C4;
    logic             ovf, ovf4;

    seq_alu #(.WIDTH(W), .MUL_STEP(1)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .opCode(opCode), .out_valid(out_valid),
        .out_ready(out_ready), .C(C), .ovf(ovf)
    );

    seq_alu #(.WIDTH(W), .MUL_STEP(4)) u_dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4),
        .A(A), .B(B), .opCode(opCode), .out_valid(out_valid4),
        .out_ready(out_ready), .C(C4), .ovf(ovf4)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [2*W:0] obs, input logic [2*W:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference: exact signed arithmetic on 128-bit sign-extended operands.
    function automatic logic [2*W-1:0] model_c(input logic [1:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic signed [2*W-1:0] sa;
        logic signed [2*W-1:0] sb;
        sa = signed'({{W{a[W-1]}}, a});
        sb = signed'({{W{b[W-1]}}, b});
        case (op)
            OP_ADD:  return sa + sb;
            OP_MUL:  return sa * sb;
            OP_SUB:  return sa - sb;
            default: return '0;
        endcase
    endfunction

    // Result does not fit in W signed bits (only reported when the feature is built in).
    function automatic logic model_ovf(input logic [1:0] op, input logic [2*W-1:0] r);
        logic hi_mixed;
        hi_mixed = !((&r[2*W-1:W-1]) || !(|r[2*W-1:W-1]));
        return OVF_ON && (op != OP_CLR) && hi_mixed;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic issue(input bit sel, input logic [1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        int  n;
        logic rdy;
        n = 0;
        @(negedge clk);
        opCode = op; A = a; B = b;
        if (sel) in_valid4 = 1'b1; else in_valid = 1'b1;
        #1;
        rdy = sel ? in_ready4 : in_ready;
        while (!rdy && n < 200) begin
            @(negedge clk);
            #1;
            rdy = sel ? in_ready4 : in_ready;
            n++;
        end
        check("accept_ready", {128'd0, rdy}, 129'd1);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_valid4 = 1'b0;
    endtask

    task automatic wait_result(input bit sel, output int lat);
        lat = 1;
        while (!(sel ? out_valid4 : out_valid) && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input bit sel, input logic [1:0] op,
                          input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [2*W-1:0] exp_c, input int exp_lat);
        int lat;
        issue(sel, op, a, b);
        wait_result(sel, lat);
        check({tag, "_latency"}, 129'(lat), 129'(exp_lat));
        check({tag, "_C"}, {1'b0, (sel ? C4 : C)}, {1'b0, exp_c});
        check({tag, "_ovf"}, {128'd0, (sel ? ovf4 : ovf)}, {128'd0, model_ovf(op, exp_c)});
        @(posedge clk);
        #1;
        check({tag, "_retired"}, {128'd0, (sel ? out_valid4 : out_valid)}, 129'd0);
    endtask

    // ---------------- scoreboard ----------------
    logic [2*W:0] exp_q[$];

    task automatic random_stream(input int n_ops);
        int           sent, got, cyc;
        bit           acc;
        logic [2*W-1:0] mc;
        logic [2*W:0] e;
        sent = 0; got = 0; cyc = 0;
        in_valid = 1'b0;
        while ((sent < n_ops || exp_q.size() != 0) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
            acc = 1'b0;
            out_ready = 1'($urandom_range(0, 1));
            if (!in_valid && sent < n_ops) begin
                opCode = 2'($urandom_range(0, 3));
                if ($urandom_range(0, 1) == 1) begin
                    A = {$urandom, $urandom};
                    B = {$urandom, $urandom};
                end else begin
                    A = W'(signed'($urandom_range(0, 40)) - 20);
                    B = W'(signed'($urandom_range(0, 40)) - 20);
                end
                in_valid = 1'b1;
            end
            #1;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("stream_spurious", 129'(exp_q.size()), 129'd1);
                end else begin
                    e = exp_q.pop_front();
                    check("stream_result", {ovf, C}, e);
                    got++;
                end
            end
            if (in_valid && in_ready) begin
                mc = model_c(opCode, A, B);
                exp_q.push_back({model_ovf(opCode, mc), mc});
                sent++;
                acc = 1'b1;
            end
            @(posedge clk);
            #1;
            if (acc) in_valid = 1'b0;
        end
        out_ready = 1'b1;
        check("stream_sent", 129'(sent), 129'(n_ops));
        check("stream_got", 129'(got), 129'(n_ops));
        check("stream_queue_empty", 129'(exp_q.size()), 129'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int lat;
        reset = 1'b1; in_valid = 1'b0; in_valid4 = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; opCode = OP_CLR;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", {128'd0, in_ready}, 129'd0);
        check("rst_out_valid", {128'd0, out_valid}, 129'd0);
        check("rst_C", {1'b0, C}, 129'd0);
        check("rst_ovf", {128'd0, ovf}, 129'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rel_in_ready", {128'd0, in_ready}, 129'd1);

        run_op("add_max", 1'b0, OP_ADD, MAX_POS, 64'd1, EXP_ADD_MAX, 2);
        run_op("sub_3_5", 1'b0, OP_SUB, 64'd3, 64'd5, EXP_M2, 2);
        run_op("mul_min", 1'b0, OP_MUL, MIN_NEG, MIN_NEG, EXP_2P126, 67);
        run_op("mul_m7_6", 1'b0, OP_MUL, NEG7, 64'd6, EXP_M42, 67);
        run_op("clr", 1'b0, OP_CLR, 64'd5, 64'd5, 128'd0, 2);
        run_op("mul4_min", 1'b1, OP_MUL, MIN_NEG, MIN_NEG, EXP_2P126, 19);
        run_op("mul4_m7_6", 1'b1, OP_MUL, NEG7, 64'd6, EXP_M42, 19);

        // Backpressure on a finished multiply, then retire and accept together.
        out_ready = 1'b0;
        issue(1'b0, OP_MUL, NEG7, 64'd6);
        wait_result(1'b0, lat);
        check("bp_mul_latency", 129'(lat), 129'd67);
        repeat (10) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", {128'd0, out_valid}, 129'd1);
            check("bp_C", {1'b0, C}, {1'b0, EXP_M42});
            check("bp_in_ready", {128'd0, in_ready}, 129'd0);
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = 1'b1; opCode = OP_ADD; A = 64'd1; B = 64'd1;
        #1;
        check("bp_release_ready", {128'd0, in_ready}, 129'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("bp_retired", {128'd0, out_valid}, 129'd0);
        wait_result(1'b0, lat);
        check("bp_add_latency", 129'(lat), 129'd2);
        check("bp_add_C", {1'b0, C}, 129'd2);
        @(posedge clk);
        #1;

        // Reset in the middle of a multiply.
        issue(1'b0, OP_MUL, NEG7, 64'd6);
        repeat (20) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("midrst_out_valid", {128'd0, out_valid}, 129'd0);
        check("midrst_C", {1'b0, C}, 129'd0);
        check("midrst_in_ready", {128'd0, in_ready}, 129'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op("after_rst_add", 1'b0, OP_ADD, 64'd2, 64'd2, 128'd4, 2);

        random_stream(100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Hard time limit so a stuck handshake cannot hang the run.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
        $fatal(1, "time limit");
    end

endmodule
